// File: rtl/mist_frame_mon_if.sv
// Frame monitor signal bundle: video/download inputs from the unit under
// test and the frame/dump/finish outputs consumed by the bench top level.
interface mist_frame_mon_if;
    logic        vs;
    logic        downloading;
    logic [31:0] frame_cnt;
    logic        new_frame;
    logic        dump_en;
    logic        dump_start;
    logic        sim_done;

    modport master (
        output vs,
        output downloading,
        input  frame_cnt,
        input  new_frame,
        input  dump_en,
        input  dump_start,
        input  sim_done
    );

    modport slave (
        input  vs,
        input  downloading,
        output frame_cnt,
        output new_frame,
        output dump_en,
        output dump_start,
        output sim_done
    );
endinterface

// File: rtl/mist_frame_mon.sv
// Frame counter driven by VGA vsync, gated by ROM download, producing the
// dump-window enable and a sticky end-of-simulation request.
module mist_frame_mon #(
    parameter bit          WAIT_DL     = 1'b1,
    parameter logic [31:0] DUMP_START  = 32'd0,
    parameter logic [31:0] DUMP_FRAMES = 32'd0,
    parameter logic [31:0] MAX_FRAMES  = 32'd0
) (
    input logic              clk,
    input logic              rst,
    mist_frame_mon_if.slave  mon
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        new_frame_q, new_frame_d;
    logic        dump_en_q, dump_en_d;
    logic        dump_start_q, dump_start_d;
    logic        sim_done_q, sim_done_d;
    logic        vs_l_q;
    logic        dl_l_q;

    logic vs_fall;
    logic dl_end;
    logic dl_start;

    assign vs_fall  = vs_l_q & ~mon.vs;
    assign dl_end   = dl_l_q & ~mon.downloading;
    assign dl_start = ~dl_l_q & mon.downloading;

    // Upper bound in 33 bits so DUMP_START+DUMP_FRAMES cannot wrap
    function automatic logic in_win(input logic [31:0] c);
        logic [32:0] hi;
        hi = {1'b0, DUMP_START} + {1'b0, DUMP_FRAMES};
        return (c >= DUMP_START) &&
               ((DUMP_FRAMES == '0) || ({1'b0, c} < hi));
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        new_frame_d = 1'b0;
        dump_en_d   = dump_en_q;
        sim_done_d  = sim_done_q;
        unique case (state_q)
            ST_WAIT: begin
                dump_en_d = 1'b0;
                if (dl_end) begin
                    state_d   = ST_RUN;
                    dump_en_d = in_win(32'd0);
                end
            end
            ST_RUN: begin
                if (WAIT_DL && dl_start) begin
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    dump_en_d = 1'b0;
                end else begin
                    if (vs_fall && (cnt_q != '1)) begin
                        cnt_d       = cnt_q + 32'd1;
                        new_frame_d = 1'b1;
                        if ((MAX_FRAMES != '0) && (cnt_d == MAX_FRAMES)) begin
                            state_d    = ST_DONE;
                            sim_done_d = 1'b1;
                        end
                    end
                    dump_en_d = in_win(cnt_d);
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
        dump_start_d = dump_en_d & ~dump_en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_DL ? ST_WAIT : ST_RUN;
            cnt_q        <= '0;
            new_frame_q  <= 1'b0;
            dump_en_q    <= 1'b0;
            dump_start_q <= 1'b0;
            sim_done_q   <= 1'b0;
            vs_l_q       <= 1'b1;
            dl_l_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            new_frame_q  <= new_frame_d;
            dump_en_q    <= dump_en_d;
            dump_start_q <= dump_start_d;
            sim_done_q   <= sim_done_d;
            vs_l_q       <= mon.vs;
            dl_l_q       <= mon.downloading;
        end
    end

    assign mon.frame_cnt  = cnt_q;
    assign mon.new_frame  = new_frame_q;
    assign mon.dump_en    = dump_en_q;
    assign mon.dump_start = dump_start_q;
    assign mon.sim_done   = sim_done_q;

endmodule

// File: tb/tb_mist_frame_mon.sv
// Bench for mist_frame_mon: six parameter sets share one stimulus stream
// and are compared every cycle against a per-set reference model.
module tb_mist_frame_mon;

    localparam int N = 6;
    localparam logic [N-1:0] C_WDL = 6'b010010;
    localparam logic [N*32-1:0] C_DS = {
        32'hFFFF_FFF0, 32'd1, 32'd0, 32'd5, 32'd2, 32'd0};
    localparam logic [N*32-1:0] C_DF = {
        32'h20, 32'd2, 32'd0, 32'd3, 32'd0, 32'd0};
    localparam logic [N*32-1:0] C_MAX = {
        32'd0, 32'd6, 32'd4, 32'd0, 32'd0, 32'd0};

    logic clk;
    logic rst;
    logic vs;
    logic dl;

    logic [31:0] o_cnt [N];
    logic        o_nf  [N];
    logic        o_de  [N];
    logic        o_ds  [N];
    logic        o_sd  [N];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mist_frame_mon_if bus ();
        assign bus.vs          = vs;
        assign bus.downloading = dl;
        assign o_cnt[g] = bus.frame_cnt;
        assign o_nf[g]  = bus.new_frame;
        assign o_de[g]  = bus.dump_en;
        assign o_ds[g]  = bus.dump_start;
        assign o_sd[g]  = bus.sim_done;
        mist_frame_mon #(
            .WAIT_DL     (C_WDL[g]),
            .DUMP_START  (C_DS[g*32 +: 32]),
            .DUMP_FRAMES (C_DF[g*32 +: 32]),
            .MAX_FRAMES  (C_MAX[g*32 +: 32])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .mon (bus)
        );
    end

    // Reference model: 0 = waiting for download, 1 = counting, 2 = finished
    int          md  [N];
    longint      mc  [N];
    logic        mnf [N];
    logic        mde [N];
    logic        mds [N];
    logic        msd [N];
    logic        mpv [N];
    logic        mpd [N];

    function automatic logic win(input int i, input longint c);
        longint s;
        longint f;
        s = longint'(C_DS[i*32 +: 32]);
        f = longint'(C_DF[i*32 +: 32]);
        return (c >= s) && ((f == 0) || (c < s + f));
    endfunction

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            logic fall, dend, dstart, old_de;
            longint mx;
            mx = longint'(C_MAX[i*32 +: 32]);
            if (rst) begin
                md[i]  = C_WDL[i] ? 0 : 1;
                mc[i]  = 0;
                mnf[i] = 0;
                mde[i] = 0;
                mds[i] = 0;
                msd[i] = 0;
                mpv[i] = 1;
                mpd[i] = 0;
            end else begin
                fall   = mpv[i] && !vs;
                dend   = mpd[i] && !dl;
                dstart = !mpd[i] && dl;
                old_de = mde[i];
                mnf[i] = 0;
                if (md[i] == 0) begin
                    if (dend) begin
                        md[i]  = 1;
                        mde[i] = win(i, mc[i]);
                    end else begin
                        mde[i] = 0;
                    end
                end else if (md[i] == 1) begin
                    if (C_WDL[i] && dstart) begin
                        md[i]  = 0;
                        mc[i]  = 0;
                        mde[i] = 0;
                    end else begin
                        if (fall && mc[i] < 64'hFFFF_FFFF) begin
                            mc[i]  = mc[i] + 1;
                            mnf[i] = 1;
                            if (mx != 0 && mc[i] == mx) begin
                                md[i]  = 2;
                                msd[i] = 1;
                            end
                        end
                        mde[i] = win(i, mc[i]);
                    end
                end
                mds[i] = mde[i] && !old_de;
                mpv[i] = vs;
                mpd[i] = dl;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("cfg%0d frame_cnt", i), o_cnt[i], mc[i][31:0]);
            chk($sformatf("cfg%0d new_frame", i), 32'(o_nf[i]), 32'(mnf[i]));
            chk($sformatf("cfg%0d dump_en", i), 32'(o_de[i]), 32'(mde[i]));
            chk($sformatf("cfg%0d dump_start", i), 32'(o_ds[i]), 32'(mds[i]));
            chk($sformatf("cfg%0d sim_done", i), 32'(o_sd[i]), 32'(msd[i]));
        end
    endtask

    task automatic step(input logic v, input logic d, input logic r);
        vs  = v;
        dl  = d;
        rst = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse(input logic d);
        step(1'b0, d, 1'b0);
        step(1'b1, d, 1'b0);
        step(1'b1, d, 1'b0);
    endtask

    initial begin
        logic rv, vv, dv;
        vs  = 1'b1;
        dl  = 1'b1;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("reset cnt", o_cnt[0], 32'd0);
        chk("reset dump_en", 32'(o_de[0]), 32'd0);
        chk("reset sim_done", 32'(o_sd[3]), 32'd0);

        step(1'b1, 1'b1, 1'b0);
        chk("A dump_en first cycle", 32'(o_de[0]), 32'd1);
        chk("A dump_start first cycle", 32'(o_ds[0]), 32'd1);
        chk("B dump_en in wait", 32'(o_de[1]), 32'd0);

        for (int k = 0; k < 3; k++) pulse(1'b1);
        chk("A cnt after 3", o_cnt[0], 32'd3);
        chk("B cnt held in wait", o_cnt[1], 32'd0);

        step(1'b0, 1'b0, 1'b0);
        chk("B dl end + vs same cycle", o_cnt[1], 32'd0);
        chk("D cnt at max", o_cnt[3], 32'd4);
        chk("D sim_done", 32'(o_sd[3]), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) pulse(1'b0);
        chk("B cnt after 3", o_cnt[1], 32'd3);
        chk("D cnt frozen", o_cnt[3], 32'd4);
        chk("D no new_frame", 32'(o_nf[3]), 32'd0);
        chk("B dump_en in window", 32'(o_de[1]), 32'd1);

        step(1'b0, 1'b1, 1'b0);
        chk("B dl start clears cnt", o_cnt[1], 32'd0);
        chk("B dl start clears dump_en", 32'(o_de[1]), 32'd0);
        step(1'b1, 1'b1, 1'b0);

        step(1'b1, 1'b1, 1'b1);
        chk("A rst cnt", o_cnt[0], 32'd0);
        chk("A rst dump_en", 32'(o_de[0]), 32'd0);
        chk("D rst sim_done", 32'(o_sd[3]), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        pulse(1'b1);
        chk("A resumes at 1", o_cnt[0], 32'd1);

        for (int k = 2; k <= 10; k++) begin
            pulse(1'b1);
            chk($sformatf("C window at %0d", k), 32'(o_de[2]),
                32'((k >= 5) && (k < 8)));
        end
        chk("F overflow-safe window", 32'(o_de[5]), 32'd0);

        dv = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rv = ($urandom_range(0, 99) == 0);
            vv = rv ? 1'b1 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) dv = ~dv;
            step(vv, dv, rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
